// File: rtl/demux_seq_ctrl.sv
`default_nettype none
// demux_seq_ctrl: N-channel select/strobe/dwell sequencer for an external analog demux.
// Rev 1.0 -- single, scan-once, continuous-scan and ping-pong modes with break-before-make.
module demux_seq_ctrl #(
  parameter int CH_W      = 5,
  parameter int NUM_CH    = 32,
  parameter int DWELL_W   = 8,
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [1:0]         cfg_mode_i,
  input  logic [CH_W-1:0]    cfg_first_i,
  input  logic [CH_W-1:0]    cfg_last_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  input  logic               stop_i,
  output logic [CH_W-1:0]    set_ch_o,
  output logic               cs_o,
  output logic               wr_o,
  output logic               demux_ena_o,
  output logic               busy_o,
  output logic               ch_done_o
);

  localparam int PH_MAX = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = (DWELL_W > PH_W) ? DWELL_W : PH_W;

  localparam logic [CNT_W-1:0] C_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] C_WR_LAST    = CNT_W'(WR_CYC - 1);
  localparam logic [CH_W:0]    C_CH_MAX     = (CH_W+1)'(NUM_CH - 1);

  localparam logic [1:0] M_SINGLE = 2'd0;
  localparam logic [1:0] M_ONCE   = 2'd1;
  localparam logic [1:0] M_CONT   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_DWELL  = 3'd4,
    S_PARK   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [CH_W-1:0]    first_q, first_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [1:0]         mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               up_q, up_d;
  logic               abort_q, abort_d;
  logic               rdy_q;
  logic               cs_q, wr_q, dena_q, busy_q, done_q;

  logic               w_stop, w_accept, w_at_end;
  logic [CH_W-1:0]    w_first_c, w_last_c, w_lo, w_hi, w_step, w_back;
  logic [1:0]         w_mode_c;

  // Ready tracks the registered state but must drop in the same cycle as stop/ena
  // so that a simultaneous stop always wins over a configuration offer.
  assign cfg_ready_o = rdy_q && ena_i && !stop_i;
  assign w_accept    = cfg_valid_i && cfg_ready_o;
  assign w_stop      = stop_i || !ena_i;

  assign w_first_c = ({1'b0, cfg_first_i} > C_CH_MAX) ? C_CH_MAX[CH_W-1:0] : cfg_first_i;
  assign w_last_c  = ({1'b0, cfg_last_i}  > C_CH_MAX) ? C_CH_MAX[CH_W-1:0] : cfg_last_i;
  assign w_mode_c  = (cfg_mode_i != M_SINGLE && w_first_c == w_last_c) ? M_ONCE : cfg_mode_i;

  assign w_lo     = (first_q <= last_q) ? first_q : last_q;
  assign w_hi     = (first_q <= last_q) ? last_q : first_q;
  assign w_at_end = up_q ? (ch_q == w_hi) : (ch_q == w_lo);
  assign w_step   = up_q ? ch_q + CH_W'(1) : ch_q - CH_W'(1);
  assign w_back   = up_q ? ch_q - CH_W'(1) : ch_q + CH_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    first_d = first_q;
    last_d  = last_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    up_d    = up_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE, S_PARK: begin
        if (w_accept) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          abort_d = 1'b0;
          first_d = w_first_c;
          last_d  = w_last_c;
          mode_d  = w_mode_c;
          dwell_d = cfg_dwell_i;
          ch_d    = w_first_c;
          up_d    = (w_last_c >= w_first_c);
        end else if (state_q == S_PARK && w_stop) begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        abort_d = abort_q || w_stop;
        if (cnt_q == C_SETUP_LAST) begin
          state_d = S_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STROBE: begin
        abort_d = abort_q || w_stop;
        if (cnt_q == C_WR_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        // A write that was started always finishes; an abort only skips the dwell.
        state_d = (abort_q || w_stop) ? S_IDLE : S_DWELL;
        cnt_d   = '0;
      end
      S_DWELL: begin
        if (w_stop) begin
          state_d = S_IDLE;
        end else if (cnt_q != CNT_W'(dwell_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = S_SETUP;
          case (mode_q)
            M_SINGLE: state_d = S_PARK;
            M_ONCE: begin
              if (w_at_end) state_d = S_IDLE;
              else          ch_d    = w_step;
            end
            M_CONT:  ch_d = w_at_end ? first_q : w_step;
            default: begin
              if (w_at_end) begin
                up_d = !up_q;
                ch_d = w_back;
              end else begin
                ch_d = w_step;
              end
            end
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      first_q <= '0;
      last_q  <= '0;
      mode_q  <= M_SINGLE;
      dwell_q <= '0;
      up_q    <= 1'b1;
      abort_q <= 1'b0;
      rdy_q   <= 1'b0;
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      dena_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      first_q <= first_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      up_q    <= up_d;
      abort_q <= abort_d;
      rdy_q   <= (state_d == S_IDLE) || (state_d == S_PARK);
      cs_q    <= (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
      wr_q    <= (state_d == S_STROBE);
      dena_q  <= (state_d == S_DWELL) || (state_d == S_PARK);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DWELL) && (cnt_d == CNT_W'(dwell_d));
    end
  end

  assign set_ch_o    = ch_q;
  assign cs_o        = cs_q;
  assign wr_o        = wr_q;
  assign demux_ena_o = dena_q;
  assign busy_o      = busy_q;
  assign ch_done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_seq_ctrl.sv
`default_nettype none
// tb_demux_seq_ctrl: table-driven and randomized checks of the demux sequencer against a timeline model.
// Rev 1.0
module tb_demux_seq_ctrl;

  localparam int CH_W      = 5;
  localparam int NUM_CH    = 20;
  localparam int DWELL_W   = 8;
  localparam int SETUP_CYC = 1;
  localparam int WR_CYC    = 2;

  localparam int K_NAT = 0;
  localparam int K_WR  = 1;
  localparam int K_DW  = 2;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               ena       = 1'b1;
  logic               cfg_valid = 1'b0;
  logic [1:0]         cfg_mode  = '0;
  logic [CH_W-1:0]    cfg_first = '0;
  logic [CH_W-1:0]    cfg_last  = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               stop      = 1'b0;
  logic               cfg_ready;
  logic [CH_W-1:0]    set_ch;
  logic               cs, wr, demux_ena, busy, ch_done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic cs, wr, dena, busy, done;
  } exp_t;

  typedef struct {
    logic               v;
    logic [1:0]         mode;
    logic [CH_W-1:0]    first;
    logic [DWELL_W-1:0] dwell;
    logic               stp;
    logic               rdy;
    exp_t               e;
  } vec_t;

  exp_t tl[$];
  vec_t tbl[17];

  demux_seq_ctrl #(
    .CH_W(CH_W), .NUM_CH(NUM_CH), .DWELL_W(DWELL_W), .SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena_i(ena), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_mode_i(cfg_mode), .cfg_first_i(cfg_first), .cfg_last_i(cfg_last), .cfg_dwell_i(cfg_dwell),
    .stop_i(stop), .set_ch_o(set_ch), .cs_o(cs), .wr_o(wr), .demux_ena_o(demux_ena),
    .busy_o(busy), .ch_done_o(ch_done)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mke(input int ch, input int c, input int w, input int d, input int b, input int dn);
    exp_t e;
    e.ch = CH_W'(ch); e.cs = c[0]; e.wr = w[0]; e.dena = d[0]; e.busy = b[0]; e.done = dn[0];
    return e;
  endfunction

  function automatic vec_t mkv(input int v, input int mode, input int first, input int dwell,
                               input int stp, input int rdy, input exp_t e);
    vec_t r;
    r.v = v[0]; r.mode = 2'(mode); r.first = CH_W'(first); r.dwell = DWELL_W'(dwell);
    r.stp = stp[0]; r.rdy = rdy[0]; r.e = e;
    return r;
  endfunction

  task automatic check_exp(input exp_t e);
    cmp("set_ch",    32'(set_ch),    32'(e.ch));
    cmp("cs",        32'(cs),        32'(e.cs));
    cmp("wr",        32'(wr),        32'(e.wr));
    cmp("demux_ena", 32'(demux_ena), 32'(e.dena));
    cmp("busy",      32'(busy),      32'(e.busy));
    cmp("ch_done",   32'(ch_done),   32'(e.done));
    cmp("break_before_make", 32'(demux_ena & (cs | wr)), 32'(0));
  endtask

  // Effective mode / clamped endpoints / channel count of a configuration.
  function automatic void eff(input int mode, input int first, input int last,
                              output int m, output int n, output int f, output int l);
    f = (first > NUM_CH - 1) ? NUM_CH - 1 : first;
    l = (last  > NUM_CH - 1) ? NUM_CH - 1 : last;
    m = (mode != 0 && f == l) ? 1 : mode;
    n = (l >= f) ? l - f + 1 : f - l + 1;
  endfunction

  // Channel of visit i: position in the first..last list, repeated or folded per mode.
  function automatic int ch_of(input int m, input int f, input int l, input int n, input int i);
    int dir;
    int k;
    int p;
    dir = (l >= f) ? 1 : -1;
    p   = 2 * n - 2;
    case (m)
      0:       k = 0;
      1:       k = i;
      2:       k = i % n;
      default: begin
        k = i % p;
        if (k >= n) k = p - k;
      end
    endcase
    return f + dir * k;
  endfunction

  task automatic push_write(input int c);
    for (int s = 0; s < SETUP_CYC; s++) tl.push_back(mke(c, 1, 0, 0, 1, 0));
    for (int s = 0; s < WR_CYC; s++)    tl.push_back(mke(c, 1, 1, 0, 1, 0));
    tl.push_back(mke(c, 1, 0, 0, 1, 0));
  endtask

  // Expected per-cycle outputs from the cycle after acceptance; stop_idx is the
  // entry after which stop (or ena=0) is raised for one cycle.
  task automatic build(input int mode, input int first, input int last, input int dwell,
                       input int nvis, input int kind, input int off, output int stop_idx);
    int m, n, f, l, c;
    eff(mode, first, last, m, n, f, l);
    tl.delete();
    stop_idx = -1;
    for (int v = 0; v < nvis; v++) begin
      c = ch_of(m, f, l, n, v);
      push_write(c);
      if (kind == K_DW && v == nvis - 1) begin
        for (int d = 0; d <= off; d++) tl.push_back(mke(c, 0, 0, 1, 1, 0));
        stop_idx = tl.size() - 1;
      end else begin
        for (int d = 0; d <= dwell; d++) tl.push_back(mke(c, 0, 0, 1, 1, (d == dwell) ? 1 : 0));
      end
    end
    if (kind == K_WR) begin
      stop_idx = tl.size() + off;
      push_write(ch_of(m, f, l, n, nvis));
    end else if (kind == K_NAT && m == 0) begin
      c = ch_of(m, f, l, n, 0);
      for (int p = 0; p < 3; p++) tl.push_back(mke(c, 0, 0, 1, 1, 0));
      stop_idx = tl.size() - 1;
    end
  endtask

  task automatic run_txn(input int mode, input int first, input int last, input int dwell,
                         input int nvis, input int kind, input int off, input int use_ena);
    int sidx;
    int lastc;
    build(mode, first, last, dwell, nvis, kind, off, sidx);
    cfg_mode  = 2'(mode);
    cfg_first = CH_W'(first);
    cfg_last  = CH_W'(last);
    cfg_dwell = DWELL_W'(dwell);
    cfg_valid = 1'b1;
    #1;
    cmp("cfg_ready_idle", 32'(cfg_ready), 32'(1));
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      stop      = 1'b0;
      ena       = 1'b1;
      check_exp(tl[i]);
      if (i == sidx) begin
        if (use_ena != 0) ena = 1'b0;
        else              stop = 1'b1;
      end
    end
    lastc = int'(tl[tl.size()-1].ch);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      stop = 1'b0;
      ena  = 1'b1;
      check_exp(mke(lastc, 0, 0, 0, 0, 0));
    end
  endtask

  initial begin
    // Single on ch 7 with dwell 3, PARK, retarget to ch 2, then stop racing a cfg offer.
    tbl[0]  = mkv(1, 0, 7, 3, 0, 1, mke(7, 1, 0, 0, 1, 0));
    tbl[1]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 1, 1, 0, 1, 0));
    tbl[2]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 1, 1, 0, 1, 0));
    tbl[3]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 1, 0, 0, 1, 0));
    tbl[4]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 0, 0, 1, 1, 0));
    tbl[5]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 0, 0, 1, 1, 0));
    tbl[6]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 0, 0, 1, 1, 0));
    tbl[7]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 0, 0, 1, 1, 1));
    tbl[8]  = mkv(0, 0, 7, 3, 0, 0, mke(7, 0, 0, 1, 1, 0));
    tbl[9]  = mkv(1, 0, 2, 0, 0, 1, mke(2, 1, 0, 0, 1, 0));
    tbl[10] = mkv(0, 0, 2, 0, 0, 0, mke(2, 1, 1, 0, 1, 0));
    tbl[11] = mkv(0, 0, 2, 0, 0, 0, mke(2, 1, 1, 0, 1, 0));
    tbl[12] = mkv(0, 0, 2, 0, 0, 0, mke(2, 1, 0, 0, 1, 0));
    tbl[13] = mkv(0, 0, 2, 0, 0, 0, mke(2, 0, 0, 1, 1, 1));
    tbl[14] = mkv(0, 0, 2, 0, 0, 0, mke(2, 0, 0, 1, 1, 0));
    tbl[15] = mkv(1, 0, 9, 0, 1, 0, mke(2, 0, 0, 0, 0, 0));
    tbl[16] = mkv(0, 0, 9, 0, 0, 1, mke(2, 0, 0, 0, 0, 0));

    #12;
    cmp("reset_cfg_ready", 32'(cfg_ready), 32'(0));
    check_exp(mke(0, 0, 0, 0, 0, 0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    cmp("ready_after_release", 32'(cfg_ready), 32'(1));

    for (int i = 0; i < 17; i++) begin
      cfg_valid = tbl[i].v;
      cfg_mode  = tbl[i].mode;
      cfg_first = tbl[i].first;
      cfg_last  = tbl[i].first;
      cfg_dwell = tbl[i].dwell;
      stop      = tbl[i].stp;
      #1;
      cmp("tbl_cfg_ready", 32'(cfg_ready), 32'(tbl[i].rdy));
      @(posedge clk); #1;
      check_exp(tbl[i].e);
    end
    cfg_valid = 1'b0;
    stop      = 1'b0;

    run_txn(1, 3, 5, 0, 3, K_NAT, 0, 0);
    run_txn(2, 18, 19, 1, 5, K_WR, 0, 0);
    run_txn(3, 1, 3, 0, 6, K_WR, 1, 0);
    run_txn(1, 6, 4, 2, 3, K_NAT, 0, 0);
    run_txn(0, 25, 0, 1, 1, K_NAT, 0, 0);
    run_txn(2, 30, 31, 0, 1, K_NAT, 0, 0);
    run_txn(0, 5, 5, 2, 0, K_WR, SETUP_CYC, 0);
    run_txn(3, 4, 2, 3, 4, K_DW, 1, 1);

    for (int t = 0; t < 30; t++) begin
      int mode, first, last, dwell, m, n, f, l, kind, nvis, off, ue;
      mode  = int'($urandom_range(0, 3));
      first = int'($urandom_range(0, 31));
      last  = int'($urandom_range(0, 31));
      dwell = int'($urandom_range(0, 4));
      ue    = int'($urandom_range(0, 1));
      eff(mode, first, last, m, n, f, l);
      kind = int'($urandom_range(0, 2));
      if (m >= 2 && kind == K_NAT) kind = K_WR;
      if (kind == K_DW && dwell == 0) kind = K_WR;
      case (kind)
        K_NAT:   nvis = (m == 0) ? 1 : n;
        K_WR:    nvis = (m == 0) ? 0 : (m == 1) ? int'($urandom_range(0, n - 1)) : int'($urandom_range(1, 6));
        default: nvis = (m == 0) ? 1 : (m == 1) ? int'($urandom_range(1, n)) : int'($urandom_range(1, 6));
      endcase
      off = (kind == K_WR) ? int'($urandom_range(0, SETUP_CYC + WR_CYC)) :
            (kind == K_DW) ? int'($urandom_range(0, dwell - 1)) : 0;
      run_txn(mode, first, last, dwell, nvis, kind, off, ue);
    end

    // Asynchronous reset landing between edges in the first STROBE cycle.
    cfg_mode  = 2'd0;
    cfg_first = CH_W'(9);
    cfg_last  = CH_W'(9);
    cfg_dwell = DWELL_W'(1);
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cmp("arst_setup_cs", 32'(cs), 32'(1));
    @(posedge clk); #1;
    cmp("arst_strobe_wr", 32'(wr), 32'(1));
    #3 rst_n = 1'b0;
    #1;
    cmp("arst_cs",        32'(cs),        32'(0));
    cmp("arst_wr",        32'(wr),        32'(0));
    cmp("arst_demux_ena", 32'(demux_ena), 32'(0));
    cmp("arst_busy",      32'(busy),      32'(0));
    cmp("arst_set_ch",    32'(set_ch),    32'(0));
    cmp("arst_cfg_ready", 32'(cfg_ready), 32'(0));
    #12 rst_n = 1'b1;
    #1;
    cmp("arst_ready_before_edge", 32'(cfg_ready), 32'(0));
    @(posedge clk); #1;
    cmp("arst_ready_first_edge", 32'(cfg_ready), 32'(1));
    cmp("arst_busy_first_edge",  32'(busy),      32'(0));
    run_txn(1, 0, 2, 1, 3, K_NAT, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
